// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer types, write FSM states, default geometry and the shift-add stride multiplier
package fb_pkg;
  localparam int unsigned LINE_STRIDE_DEF = 800;
  localparam logic [19:0] DBUF_OFFSET_DEF = 20'h5DC00;
  localparam int unsigned XRES_DEF = 640;
  localparam int unsigned YRES_DEF = 480;
  typedef struct packed {
    logic [4:0] b;
    logic [5:0] g;
    logic [4:0] r;
  } rgb565_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    rgb565_t    color;
  } px_entry_t;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_PULSE, ST_HOLD} wr_state_e;
  function automatic logic [19:0] mul_stride(input logic [9:0] y, input int unsigned k);
    logic [19:0] acc;
    acc = '0;
    for (int i = 0; i < 20; i++)
      if (k[i]) acc = acc + (20'(y) << i);
    return acc;
  endfunction
endpackage

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: synchronous FIFO with registered read data (wr/rd enables in, head data, full/empty out)
module fb_sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] rd_data_q;
  logic do_wr, do_rd;
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) & (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign do_wr = wr_en_i & ~full_o;
  assign do_rd = rd_en_i & ~empty_o;
  assign rd_data_o = rd_data_q;
  always_ff @(posedge clk_i)
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + (AW+1)'(do_wr);
      rd_ptr_q <= rd_ptr_q + (AW+1)'(do_rd);
      if (do_rd) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: queued RGB565 back-buffer writer with hardware clear and vblank swap (pixel/clear/swap in; SRAM write port and arbiter request out)
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned LINE_STRIDE = LINE_STRIDE_DEF,
  parameter logic [19:0] DBUF_OFFSET = DBUF_OFFSET_DEF,
  parameter int unsigned XRES        = XRES_DEF,
  parameter int unsigned YRES        = YRES_DEF
) (
  input  logic        BOARD_CLK,
  input  logic        RESET_N,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic [15:0] px_color,
  input  logic        clear_req,
  input  logic [15:0] clear_color,
  input  logic        swap_req,
  input  logic        vblank,
  output logic        front_buffer,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_WDATA,
  output logic        SRAM_WE_N
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] XRES_W = 11'(XRES);
  localparam logic [10:0] YRES_W = 11'(YRES);
  localparam logic [9:0] XLAST = 10'(XRES - 1);
  localparam logic [9:0] YLAST = 10'(YRES - 1);
  wr_state_e state_q, state_d;
  logic [CW-1:0] pend_q, pend_d;
  logic ready_q, ready_d, staged_q, staged_d, src_q, src_d;
  logic clr_q, clr_d, swap_q, swap_d, front_q, front_d;
  logic [9:0] cx_q, cx_d, cy_q, cy_d;
  logic [15:0] clr_color_q, clr_color_d, data_q, data_d;
  logic [19:0] addr_q, addr_d;
  px_entry_t head;
  logic fifo_full, fifo_empty;
  logic idle, accept, start_clr, consume, drop, start_px, pop, retire, do_swap, clr_new, clr_last;
  logic [9:0] sel_x, sel_y;
  logic [19:0] base;
  // pend_q counts every accepted pixel until its write retires (or it is dropped),
  // so the in-flight and prefetched entries occupy queue capacity too
  assign accept = px_valid & ready_q & ~fifo_full;
  fb_sync_fifo #(.WIDTH($bits(px_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (BOARD_CLK),
    .rst_ni   (RESET_N),
    .wr_en_i  (accept),
    .wr_data_i({px_x, px_y, px_color}),
    .rd_en_i  (pop),
    .rd_data_o(head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );
  assign idle = state_q == ST_IDLE;
  assign start_clr = idle & clr_q;
  // staged_q marks a popped head waiting in the FIFO read register
  assign consume = idle & ~clr_q & staged_q;
  assign drop = consume & (({1'b0, head.x} >= XRES_W) | ({1'b0, head.y} >= YRES_W));
  assign start_px = consume & ~drop;
  assign pop = ~fifo_empty & (~staged_q | consume);
  assign retire = (state_q == ST_HOLD) & src_q;
  assign do_swap = vblank & swap_q & idle & (pend_q == '0) & ~clr_q;
  assign clr_new = clear_req & ~clr_q;
  assign clr_last = (cx_q == XLAST) & (cy_q == YLAST);
  assign sel_x = clr_q ? cx_q : head.x;
  assign sel_y = clr_q ? cy_q : head.y;
  assign base = front_q ? 20'd0 : DBUF_OFFSET;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = (start_clr | start_px) ? ST_REQ : ST_IDLE;
      ST_REQ:   state_d = mem_grant ? ST_PULSE : ST_REQ;
      ST_PULSE: state_d = ST_HOLD;
      default:  state_d = ST_IDLE;
    endcase
    pend_d = pend_q + CW'(accept) - CW'(retire | drop);
    ready_d = pend_d < CW'(FIFO_DEPTH);
    staged_d = pop | (staged_q & ~consume);
    src_d = start_clr ? 1'b0 : (start_px ? 1'b1 : src_q);
    clr_d = clr_q ? ~(start_clr & clr_last) : clear_req;
    cx_d = clr_new ? 10'd0 : (start_clr ? ((cx_q == XLAST) ? 10'd0 : cx_q + 10'd1) : cx_q);
    cy_d = clr_new ? 10'd0 : ((start_clr & (cx_q == XLAST)) ? cy_q + 10'd1 : cy_q);
    clr_color_d = clr_new ? clear_color : clr_color_q;
    addr_d = (start_clr | start_px) ? base + 20'(sel_x) + mul_stride(sel_y, LINE_STRIDE) : addr_q;
    data_d = start_clr ? clr_color_q : (start_px ? head.color : data_q);
    swap_d = ~do_swap & (swap_q | swap_req);
    front_d = front_q ^ do_swap;
  end
  always_ff @(posedge BOARD_CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pend_q <= '0;
      ready_q <= 1'b0;
      staged_q <= 1'b0;
      src_q <= 1'b0;
      clr_q <= 1'b0;
      swap_q <= 1'b0;
      front_q <= 1'b0;
      cx_q <= '0;
      cy_q <= '0;
      clr_color_q <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ready_q <= ready_d;
      staged_q <= staged_d;
      src_q <= src_d;
      clr_q <= clr_d;
      swap_q <= swap_d;
      front_q <= front_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      clr_color_q <= clr_color_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  assign px_ready = ready_q;
  assign front_buffer = front_q;
  assign busy = (pend_q != '0) | clr_q | ~idle | swap_q;
  assign mem_req = ~idle;
  assign SRAM_WE_N = state_q != ST_PULSE;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WDATA = data_q;
endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side engine for the shared SRAM framebuffer: accepts RGB565 pixel writes from the renderer, queues them, and drives SRAM write cycles into the back buffer through an arbitrated memory slot. Provides hardware clear-screen and vblank-synchronised double-buffer swap. Its `front_buffer` output selects which buffer the VGA scan-out reads. Sits between the renderer and the SRAM arbiter, on the board clock domain.

## Interface
- `FIFO_DEPTH`, 8: pixel queue entries, power of two.
- `LINE_STRIDE`, 800: words per framebuffer line; must match scan-out addressing.
- `DBUF_OFFSET`, 'h5DC00: word base of buffer 1; buffer 0 is based at 0.
- `XRES`, 640 / `YRES`, 480: visible pixel bounds.
- `BOARD_CLK` in 1: sole clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `px_valid` in 1: pixel write request.
- `px_ready` out 1: queue can accept; transfer on `px_valid & px_ready`.
- `px_x`, `px_y` in 10 each: pixel coordinate.
- `px_color` in 16: RGB565, B[15:11] G[10:5] R[4:0].
- `clear_req` in 1: one-cycle pulse, fill back buffer with `clear_color`.
- `clear_color` in 16: sampled on the `clear_req` cycle.
- `swap_req` in 1: one-cycle pulse, request buffer swap.
- `vblank` in 1: high during vertical blanking (already synchronised to `BOARD_CLK`).
- `front_buffer` out 1: buffer being displayed; writes go to `~front_buffer`.
- `busy` out 1: queue non-empty, clear active, write in flight, or swap pending.
- `mem_req` out 1: requesting the SRAM write slot.
- `mem_grant` in 1: arbiter grant, sampled only in REQ.
- `SRAM_ADDR` out 20, `SRAM_WDATA` out 16, `SRAM_WE_N` out 1: SRAM write port.

## Operation
- Reset values: `px_ready`=0 while `RESET_N` low, 1 on first cycle after release (queue empty); `front_buffer`=0, `busy`=0, `mem_req`=0, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_WDATA`=0; FIFO, clear counters, swap/clear pending flags cleared.
- Pixel queue: `px_ready` = not full. Out-of-range pixels (`px_x>=XRES` or `px_y>=YRES`) are accepted and dropped at pop, no SRAM cycle.
- Address: `SRAM_ADDR = base + px_x + LINE_STRIDE*px_y`, base = 0 or `DBUF_OFFSET` per `~front_buffer`; computed in 20 bits, no overflow for legal parameters.
- Write FSM: IDLE → REQ → PULSE → HOLD → IDLE.
  - IDLE: source select (clear has priority over queue), latch address/data into `SRAM_ADDR`/`SRAM_WDATA`.
  - REQ: `mem_req`=1; wait for `mem_grant`, unbounded.
  - PULSE: `mem_req`=1, `SRAM_WE_N`=0 exactly one cycle.
  - HOLD: `mem_req`=1, `SRAM_WE_N`=1, address/data held.
- Clear: `clear_req` sets clear mode; x/y counters scan 0..XRES-1 per line, 0..YRES-1 lines, row-major, through the same FSM; queued pixels wait until the clear finishes. `clear_req` during a clear is ignored.
- Swap: `swap_req` sets `swap_pending`; a second request while pending is absorbed. `front_buffer` toggles on the first cycle with `vblank`=1, `swap_pending`=1, FSM in IDLE, queue empty, no clear active; `swap_pending` clears on that cycle. Pixels queued after `swap_req` therefore land in the old back buffer before the toggle.
- Simultaneous `clear_req` and `swap_req`: both are captured; the swap waits for the clear.

## Timing
- Pixel accepted into an empty queue at edge t with FSM idle: popped in IDLE at t+1, `mem_req` high after t+2; with `mem_grant` held high, `SRAM_WE_N` low for the cycle after t+3. Addr/data are stable from one cycle before through one cycle after the WE pulse.
- Throughput: 4 cycles per pixel with grant tied high.
- Full clear: XRES·YRES·4 cycles minimum (1,228,800 at defaults).
- `front_buffer` changes only on a clock edge, never mid-write.
- Reset mid-write: `SRAM_WE_N` returns to 1 and `mem_req` to 0 asynchronously; the interrupted write is lost.

## Structure
- Shared package `fb_pkg`: `rgb565_t` packed struct, FSM state enum, default `LINE_STRIDE`/`DBUF_OFFSET`/`XRES`/`YRES` constants.
- One sub-module: `fb_sync_fifo` (parameterised width/depth, full/empty, registered read), holding 36-bit {x, y, color} entries.
- `y*LINE_STRIDE` is computed with a multiply-by-constant (shift-add); no DSP required.

## Test plan
- Grant tied 1, write (x=3, y=2, 'hF800), `front_buffer`=0 → one WE pulse at `SRAM_ADDR`='h5DC00+1603, `SRAM_WDATA`='hF800, 4 cycles after accept.
- Hold grant 0 for 20 cycles while pushing 9 pixels (depth 8) → `px_ready` drops after 8 accepted, `mem_req` stays high, no WE pulse; release grant → all pixels written in order.
- Pixel (x=640, y=0) → accepted, no WE pulse, `busy` deasserts.
- `clear_req` with 'h001F at reduced XRES=4/YRES=2 → 8 writes at base+{0..3, 800..803}, then queued pixel written.
- `swap_req` with `vblank`=0 → `front_buffer` holds; `vblank`=1 with queue empty → toggles to 1; next pixel (0,0) writes to address 0.
- Assert `RESET_N` low during PULSE → `SRAM_WE_N`=1 and `mem_req`=0 immediately; all outputs at reset values.
